// File: rtl/cache_bus_arbiter_pkg.sv
// Shared definitions for the cache bus arbiter.
// Contents:
//   bus_state_t - arbiter transaction phase (IDLE / ADDR / DATA)
//   SIZE_*      - transfer size codes carried on *_size
//   OWNER_*     - encoding of the owner / last-served registers
//   bus_req_t   - one master's request bundle (req, wr, size, addr, wdata)
package cache_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } bus_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/cache_bus_arbiter_rr_pick2.sv
// rr_pick2: two-input selector used for the IDLE grant decision.
// Ports:
//   req0  - request from master 0 (i-cache)
//   req1  - request from master 1 (d-cache)
//   last  - master served most recently (0 = master 0, 1 = master 1)
//   valid - at least one request present
//   grant - chosen master (0 = master 0, 1 = master 1); meaningful when valid
// Parameter RR: 1 = round-robin on contention, 0 = master 1 always wins.
module rr_pick2 #(
  parameter bit RR = 1'b1
) (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic grant
);

  // Grant selection: contention resolved by RR policy, otherwise the lone requester.
  always_comb begin
    valid = req0 | req1;
    grant = 1'b0;
    if (req0 && req1) begin
      grant = RR ? ~last : 1'b1;
    end else if (req1) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: shares one bridge port (m_*) between the i-cache and
// d-cache request ports. One transaction in flight at a time; the owner's
// request fields are muxed combinationally onto m_*, and the bridge's
// accept / complete strobes are routed back to the owner only.
// Ports:
//   clk, rst                          - clock, asynchronous active-low reset
//   i_req/i_wr/i_size/i_addr/i_wdata  - i-cache request
//   i_rdata/i_addr_ok/i_data_ok       - i-cache response
//   d_*                               - d-cache port, same meaning as i_*
//   m_req/m_wr/m_size/m_addr/m_wdata  - request to the bridge
//   m_rdata/m_addr_ok/m_data_ok       - bridge response
// Parameter RR: 1 = round-robin on contention, 0 = d-cache priority.
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] i_rdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  bus_state_t state_r;
  bus_state_t state_next_s;
  logic       owner_r;
  logic       owner_next_s;
  logic       last_r;
  logic       last_next_s;

  bus_req_t   i_bus_s;
  bus_req_t   d_bus_s;
  bus_req_t   own_bus_s;
  logic       pick_valid_s;
  logic       pick_grant_s;
  logic       own_addr_ok_s;
  logic       own_data_ok_s;

  assign i_bus_s   = {i_req, i_wr, i_size, i_addr, i_wdata};
  assign d_bus_s   = {d_req, d_wr, d_size, d_addr, d_wdata};
  assign own_bus_s = (owner_r == OWNER_D) ? d_bus_s : i_bus_s;

  // Read data is broadcast; only data_ok tells a master it is valid.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // Strobes go to the owner only, so a waiting master never sees a stray ack.
  assign i_addr_ok = own_addr_ok_s & (owner_r == OWNER_I);
  assign i_data_ok = own_data_ok_s & (owner_r == OWNER_I);
  assign d_addr_ok = own_addr_ok_s & (owner_r == OWNER_D);
  assign d_data_ok = own_data_ok_s & (owner_r == OWNER_D);

  rr_pick2 #(
    .RR (RR != 0)
  ) u_pick (
    .req0  (i_req),
    .req1  (d_req),
    .last  (last_r),
    .valid (pick_valid_s),
    .grant (pick_grant_s)
  );

  // State, owner and last-served registers; reset leaves i-cache first in line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      owner_r <= OWNER_I;
      last_r  <= OWNER_D;
    end else begin
      state_r <= state_next_s;
      owner_r <= owner_next_s;
      last_r  <= last_next_s;
    end
  end

  // Next-state logic and bridge-side request mux.
  always_comb begin
    state_next_s  = state_r;
    owner_next_s  = owner_r;
    last_next_s   = last_r;
    m_req         = 1'b0;
    m_wr          = 1'b0;
    m_size        = 2'd0;
    m_addr        = 32'd0;
    m_wdata       = 32'd0;
    own_addr_ok_s = 1'b0;
    own_data_ok_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          owner_next_s = pick_grant_s;
          state_next_s = ST_ADDR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_ADDR: begin
        m_req   = own_bus_s.req;
        m_wr    = own_bus_s.wr;
        m_size  = own_bus_s.size;
        m_addr  = own_bus_s.addr;
        m_wdata = own_bus_s.wdata;
        if (m_addr_ok) begin
          own_addr_ok_s = 1'b1;
          if (m_data_ok) begin
            // Accept and complete in one cycle: finish the transfer now.
            own_data_ok_s = 1'b1;
            last_next_s   = owner_r;
            state_next_s  = ST_IDLE;
          end else begin
            state_next_s = ST_DATA;
          end
        end else if (!own_bus_s.req) begin
          // Owner withdrew before acceptance: nothing reached the bridge.
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ADDR;
        end
      end

      ST_DATA: begin
        // Request fields stay on the owner; m_req is low once accepted.
        m_wr    = own_bus_s.wr;
        m_size  = own_bus_s.size;
        m_addr  = own_bus_s.addr;
        m_wdata = own_bus_s.wdata;
        if (m_data_ok) begin
          own_data_ok_s = 1'b1;
          last_next_s   = owner_r;
          state_next_s  = ST_IDLE;
        end else begin
          state_next_s = ST_DATA;
        end
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed, table-driven bench for cache_bus_arbiter. Two instances share the
// stimulus: u_rr (RR=1) is checked by the cycle table and the reset sequence,
// u_fix (RR=0) by the fixed-priority sequence.
module tb_cache_bus_arbiter;
  import cache_bus_arbiter_pkg::*;

  localparam logic [31:0] I_ADDR  = 32'hBFC0_0000;
  localparam logic [31:0] I_WDATA = 32'h1234_5678;
  localparam logic [31:0] D_ADDR  = 32'h8000_0003;
  localparam logic [31:0] D_WDATA = 32'h0000_00AB;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;

  logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata;
  logic        a_i_addr_ok, a_i_data_ok, a_d_addr_ok, a_d_data_ok, a_m_req, a_m_wr;
  logic [1:0]  a_m_size;
  logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
  logic        b_i_addr_ok, b_i_data_ok, b_d_addr_ok, b_d_data_ok, b_m_req, b_m_wr;
  logic [1:0]  b_m_size;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.RR(1)) u_rr (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(a_i_rdata), .i_addr_ok(a_i_addr_ok), .i_data_ok(a_i_data_ok),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(a_d_rdata), .d_addr_ok(a_d_addr_ok), .d_data_ok(a_d_data_ok),
    .m_req(a_m_req), .m_wr(a_m_wr), .m_size(a_m_size), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
  );

  cache_bus_arbiter #(.RR(0)) u_fix (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(b_i_rdata), .i_addr_ok(b_i_addr_ok), .i_data_ok(b_i_data_ok),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(b_d_rdata), .d_addr_ok(b_d_addr_ok), .d_data_ok(b_d_data_ok),
    .m_req(b_m_req), .m_wr(b_m_wr), .m_size(b_m_size), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
  );

  // One cycle of the table: inputs for that cycle and the expected outputs.
  // esrc: 0 = m_* payload all zero, 1 = i-cache payload, 2 = d-cache payload, 3 = not checked.
  // eok : {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}
  typedef struct {
    logic        rst;
    logic        ireq;
    logic        dreq;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        emreq;
    logic [1:0]  esrc;
    logic [3:0]  eok;
  } vec_t;

  vec_t tbl [26];

  function automatic logic [66:0] exp_pay(input logic [1:0] src);
    case (src)
      2'd1:    exp_pay = {1'b0, SIZE_WORD, I_ADDR, I_WDATA};
      2'd2:    exp_pay = {1'b1, SIZE_BYTE, D_ADDR, D_WDATA};
      default: exp_pay = 67'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst ireq dreq aok dok rdata         emreq esrc eok
    // Single read from the i-cache.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 2'd1, 4'b0000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 2'd1, 4'b1000};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5555_0000, 1'b0, 2'd3, 4'b0000};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3C1D_BFC0, 1'b0, 2'd3, 4'b0100};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000};
    // d-cache byte write, accepted and completed in the same cycle.
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,         1'b1, 2'd2, 4'b0011};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000};
    // Reset with both requesting, then round-robin i, d, i, d.
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,         1'b0, 2'd0, 4'b0000};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'd1, 4'b1000};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1111_0001, 1'b0, 2'd3, 4'b0100};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'd2, 4'b0010};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2222_0002, 1'b0, 2'd3, 4'b0001};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3333_0003, 1'b1, 2'd1, 4'b1100};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2'd2, 4'b0000};
    // d withdraws in ADDR: abort, then pending i is granted.
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'd2, 4'b0000};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 2'd1, 4'b1000};
    tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'd3, 4'b0000};
    tbl[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 2'd3, 4'b0100};
    tbl[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000};

    rst = 1'b0;
    i_req = 1'b0; i_wr = 1'b0; i_size = SIZE_WORD; i_addr = I_ADDR; i_wdata = I_WDATA;
    d_req = 1'b0; d_wr = 1'b1; d_size = SIZE_BYTE; d_addr = D_ADDR; d_wdata = D_WDATA;
    m_rdata = 32'h0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    next_cycle();
    next_cycle();

    // Table-driven cycles on the round-robin instance.
    for (int k = 0; k < 26; k++) begin
      logic [4:0]  got_ok;
      logic [66:0] got_pay;
      logic        pay_ok;
      logic        rd_ok;
      rst       = tbl[k].rst;
      i_req     = tbl[k].ireq;
      d_req     = tbl[k].dreq;
      m_addr_ok = tbl[k].aok;
      m_data_ok = tbl[k].dok;
      m_rdata   = tbl[k].rdata;
      #3;
      got_ok  = {a_m_req, a_i_addr_ok, a_i_data_ok, a_d_addr_ok, a_d_data_ok};
      got_pay = {a_m_wr, a_m_size, a_m_addr, a_m_wdata};
      pay_ok  = (tbl[k].esrc == 2'd3) || (got_pay === exp_pay(tbl[k].esrc));
      rd_ok   = (a_i_rdata === tbl[k].rdata) && (a_d_rdata === tbl[k].rdata);
      n_tests++;
      if (!((got_ok === {tbl[k].emreq, tbl[k].eok}) && pay_ok && rd_ok)) begin
        n_fail++;
        $display("FAIL row%0d: m_req+oks got %b exp %b, payload %h exp src %0d, i_rdata %h d_rdata %h exp %h",
                 k, got_ok, {tbl[k].emreq, tbl[k].eok}, got_pay, tbl[k].esrc,
                 a_i_rdata, a_d_rdata, tbl[k].rdata);
      end
      next_cycle();
    end

    // Asynchronous reset in the middle of a d-cache DATA phase.
    d_req = 1'b1;                                  // IDLE -> ADDR(d)
    next_cycle();
    m_addr_ok = 1'b1;                              // ADDR accepted -> DATA
    #3;
    chk("rst_seq_d_addr_ok", {63'd0, a_d_addr_ok}, 64'd1);
    next_cycle();
    d_req = 1'b0; m_addr_ok = 1'b0;
    #3;
    rst = 1'b0; m_data_ok = 1'b1;                  // reset lands between edges
    #1;
    chk("rst_mid_data_outs",
        {59'd0, a_m_req, a_i_addr_ok, a_i_data_ok, a_d_addr_ok, a_d_data_ok}, 64'd0);
    next_cycle();
    m_data_ok = 1'b0; rst = 1'b1;
    i_req = 1'b1;                                  // first request after release
    #3;
    chk("post_rst_idle_m_req", {63'd0, a_m_req}, 64'd0);
    next_cycle();
    m_addr_ok = 1'b1;
    #3;
    chk("post_rst_addr", {30'd0, a_m_req, a_i_addr_ok, a_m_addr}, {30'd0, 1'b1, 1'b1, I_ADDR});
    next_cycle();
    i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h0BAD_F00D;
    #3;
    chk("post_rst_data_ok", {31'd0, a_i_data_ok, a_i_rdata}, {31'd0, 1'b1, 32'h0BAD_F00D});
    next_cycle();
    m_data_ok = 1'b0;

    // Fixed priority instance: d served while d_req is held, i only afterwards.
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    for (int t = 0; t < 5; t++) begin
      logic        exp_d;
      logic [31:0] exp_addr;
      exp_d    = (t < 3);
      exp_addr = exp_d ? D_ADDR : I_ADDR;
      i_req = 1'b1;
      d_req = exp_d;
      m_addr_ok = 1'b0; m_data_ok = 1'b0;
      #3;
      chk($sformatf("fix_idle%0d_m_req", t), {63'd0, b_m_req}, 64'd0);
      next_cycle();
      m_addr_ok = 1'b1; m_data_ok = 1'b1;
      #3;
      chk($sformatf("fix_grant%0d", t),
          {27'd0, b_m_req, b_i_addr_ok, b_i_data_ok, b_d_addr_ok, b_d_data_ok, b_m_addr},
          {27'd0, 1'b1, ~exp_d, ~exp_d, exp_d, exp_d, exp_addr});
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
